prog_timer: RTL and testbench
=============================

Name: prog_timer

Overview:
- Parametrised general-purpose timer; successor to the fixed-function tick timer.
- Adds prescaler, up/down counting, periodic/one-shot modes, start/stop control, a compare output for PWM generation and a sticky interrupt flag.
- Serves as the time base for the PWM generator and the system housekeeping timers.

Parameters:
- TIMER_BITS, 8, width of count, final_value and compare_value.
- PRESCALE_BITS, 4, width of the prescaler divisor.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  global count enable; low freezes prescaler and count.
- start  input  1  one-cycle pulse; (re)starts the timer.
- stop  input  1  one-cycle pulse; halts the timer.
- mode_oneshot  input  1  1 = one-shot, 0 = periodic.
- dir_down  input  1  1 = count down, 0 = count up.
- prescale  input  PRESCALE_BITS  count steps every prescale+1 enabled cycles.
- final_value  input  TIMER_BITS  terminal value (up) / reload value (down).
- compare_value  input  TIMER_BITS  PWM compare threshold.
- irq_clr  input  1  clears irq.
- count  output  TIMER_BITS  current count register.
- running  output  1  high in RUN state.
- tick  output  1  registered one-cycle terminal pulse.
- cmp_out  output  1  PWM level.
- irq  output  1  sticky terminal flag.

Behaviour:
- Reset (reset=0, async) values:
  - count=0, pre_cnt=0, state=IDLE.
  - running=0, tick=0, irq=0, cmp_out=0.
- States:
  - IDLE: count held, prescaler held at 0.
  - RUN: counting.
- Control, sampled every cycle regardless of enable:
  - start: go to RUN. Load count = 0 (up) or final_value (down). Clear pre_cnt.
  - start while in RUN: same reload (restart).
  - stop: RUN->IDLE, count held.
  - start and stop in the same cycle: stop wins.
- Prescaler (only in RUN with enable=1):
  - pre_cnt increments each cycle.
  - When pre_cnt==prescale, a step occurs and pre_cnt returns to 0.
  - prescale=0 gives a step every enabled cycle.
- Step, up mode:
  - count != final_value: count+1.
  - count == final_value: terminal event.
- Step, down mode:
  - count != 0: count-1.
  - count == 0: terminal event.
- Terminal event:
  - Periodic: count reloads (0 up / final_value down), stays in RUN.
  - One-shot: count holds its terminal value, state->IDLE.
  - tick=1 on the cycle after the terminal step, for exactly one cycle.
- irq: set by terminal event, cleared by irq_clr. Simultaneous set and clear: set wins.
- final_value=0:
  - Up mode: every step is terminal; count stays 0.
  - Down mode: same behaviour.
- final_value changed mid-run:
  - Up mode: takes effect at the next comparison; if count already exceeds final_value, count wraps through 2^TIMER_BITS-1 to 0 before matching.
  - Down mode: takes effect at next reload.
- cmp_out = running AND (count < compare_value), combinational from registers.
  - compare_value=0: always 0.
  - compare_value > final_value (up, periodic): constant 1 while running.
- Arithmetic is unsigned modulo 2^TIMER_BITS.
- Reset mid-run returns to reset values immediately; no tick is emitted.

Optional Feature:
- Macro: PROG_TIMER_CAPTURE_EN.
- Defined:
  - Adds ports capture_in (input, 1), capture_value (output, TIMER_BITS) and cap_valid (output, 1).
  - capture_in passes through a 2-flop synchroniser.
  - A rising edge on the synchronised signal latches count into capture_value and sets cap_valid. Capture works in IDLE or RUN.
  - cap_valid clears on irq_clr; a new capture in the same cycle wins.
  - capture_value=0 and cap_valid=0 on reset.
- Undefined: these ports and that logic are absent; all other behaviour is identical.

Test Plan:
- Reset release, no start, 20 cycles -> count=0, running=0, tick=0, irq=0 throughout.
- Up, periodic, prescale=0, final_value=3, start -> count 0,1,2,3,0...; tick every 4 cycles; irq set after first terminal; irq_clr clears it.
- Down, one-shot, prescale=2, final_value=2, start -> count steps every 3 cycles 2,1,0; one tick; running drops; count holds 0.
- Up, periodic, final_value=9, compare_value=3 -> cmp_out high for counts 0-2, low for 3-9 (30% duty); enable low for 5 cycles freezes count and cmp_out.
- start and stop asserted together while running -> IDLE, count held. irq_clr coincident with terminal event -> irq stays 1.
- PROG_TIMER_CAPTURE_EN defined: capture_in rising edge while count=5 -> capture_value=5 within 3 cycles, cap_valid=1.

Source files
------------

// File: rtl/prog_timer_if.sv
// Control and status bundle for prog_timer. The master side drives the control
// inputs and the slave side (the timer) returns the count and status signals.
interface prog_timer_if #(
  parameter int TIMER_BITS    = 8,
  parameter int PRESCALE_BITS = 4
);
  // Control inputs: start, stop and irq_clr are one-cycle pulses that are
  // sampled on every rising clock edge, whether or not enable is high.
  logic                     enable;
  logic                     start;
  logic                     stop;
  logic                     mode_oneshot;
  logic                     dir_down;
  logic [PRESCALE_BITS-1:0] prescale;
  logic [TIMER_BITS-1:0]    final_value;
  logic [TIMER_BITS-1:0]    compare_value;
  logic                     irq_clr;

  // Status outputs
  logic [TIMER_BITS-1:0]    count;
  logic                     running;
  logic                     tick;
  logic                     cmp_out;
  logic                     irq;
  logic                     state_dbg;

`ifdef PROG_TIMER_CAPTURE_EN
  logic                     capture_in;
  logic [TIMER_BITS-1:0]    capture_value;
  logic                     cap_valid;

  modport master (
    output enable, start, stop, mode_oneshot, dir_down, prescale,
           final_value, compare_value, irq_clr, capture_in,
    input  count, running, tick, cmp_out, irq, state_dbg,
           capture_value, cap_valid
  );

  modport slave (
    input  enable, start, stop, mode_oneshot, dir_down, prescale,
           final_value, compare_value, irq_clr, capture_in,
    output count, running, tick, cmp_out, irq, state_dbg,
           capture_value, cap_valid
  );
`else
  modport master (
    output enable, start, stop, mode_oneshot, dir_down, prescale,
           final_value, compare_value, irq_clr,
    input  count, running, tick, cmp_out, irq, state_dbg
  );

  modport slave (
    input  enable, start, stop, mode_oneshot, dir_down, prescale,
           final_value, compare_value, irq_clr,
    output count, running, tick, cmp_out, irq, state_dbg
  );
`endif
endinterface

// File: rtl/prog_timer.sv
// Programmable timer: prescaler, up/down count, periodic/one-shot, PWM compare, sticky irq.
// Optional count capture on an asynchronous input when PROG_TIMER_CAPTURE_EN is defined.
module prog_timer #(
  parameter int TIMER_BITS    = 8,
  parameter int PRESCALE_BITS = 4
) (
  input  logic         clk,
  input  logic         reset,
  prog_timer_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [TIMER_BITS-1:0]    CNT_ONE = TIMER_BITS'(1);
  localparam logic [PRESCALE_BITS-1:0] PRE_ONE = PRESCALE_BITS'(1);

  state_e                   state_q;
  logic [TIMER_BITS-1:0]    count_q;
  logic [PRESCALE_BITS-1:0] pre_cnt_q;
  logic                     tick_q;
  logic                     irq_q;

  logic                     step;
  logic                     terminal;
  logic [TIMER_BITS-1:0]    reload_val;

  // A step only happens when no start/stop pulse overrides this cycle.
  always_comb begin
    step       = (state_q == RUN) && bus.enable && !bus.stop && !bus.start
                 && (pre_cnt_q == bus.prescale);
    terminal   = step && (bus.dir_down ? (count_q == '0)
                                       : (count_q == bus.final_value));
    reload_val = bus.dir_down ? bus.final_value : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      pre_cnt_q <= '0;
      tick_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      tick_q <= terminal;

      if (terminal) begin
        irq_q <= 1'b1;
      end else if (bus.irq_clr) begin
        irq_q <= 1'b0;
      end

      if (bus.stop) begin
        if (state_q == RUN) begin
          state_q   <= IDLE;
          pre_cnt_q <= '0;
        end
      end else if (bus.start) begin
        state_q   <= RUN;
        count_q   <= reload_val;
        pre_cnt_q <= '0;
      end else if ((state_q == RUN) && bus.enable) begin
        if (pre_cnt_q == bus.prescale) begin
          pre_cnt_q <= '0;
          if (terminal) begin
            // One-shot leaves the count parked on its terminal value.
            if (bus.mode_oneshot) begin
              state_q <= IDLE;
            end else begin
              count_q <= reload_val;
            end
          end else if (bus.dir_down) begin
            count_q <= count_q - CNT_ONE;
          end else begin
            count_q <= count_q + CNT_ONE;
          end
        end else begin
          pre_cnt_q <= pre_cnt_q + PRE_ONE;
        end
      end
    end
  end

  assign bus.count     = count_q;
  assign bus.running   = (state_q == RUN);
  assign bus.tick      = tick_q;
  assign bus.irq       = irq_q;
  assign bus.state_dbg = state_q;
  assign bus.cmp_out   = (state_q == RUN) && (count_q < bus.compare_value);

`ifdef PROG_TIMER_CAPTURE_EN
  logic                  cap_s1_q;
  logic                  cap_s2_q;
  logic                  cap_s3_q;
  logic [TIMER_BITS-1:0] cap_val_q;
  logic                  cap_valid_q;
  logic                  cap_rise;

  // Edge detect on the synchroniser output, not on the raw pin.
  assign cap_rise = cap_s2_q && !cap_s3_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_s1_q    <= 1'b0;
      cap_s2_q    <= 1'b0;
      cap_s3_q    <= 1'b0;
      cap_val_q   <= '0;
      cap_valid_q <= 1'b0;
    end else begin
      cap_s1_q <= bus.capture_in;
      cap_s2_q <= cap_s1_q;
      cap_s3_q <= cap_s2_q;
      if (cap_rise) begin
        cap_val_q   <= count_q;
        cap_valid_q <= 1'b1;
      end else if (bus.irq_clr) begin
        cap_valid_q <= 1'b0;
      end
    end
  end

  assign bus.capture_value = cap_val_q;
  assign bus.cap_valid     = cap_valid_q;
`endif

endmodule

// File: tb/tb_prog_timer.sv
// Directed bench for prog_timer; expected values are hand-computed per step.
// Capture checks are included when PROG_TIMER_CAPTURE_EN is defined.
module tb_prog_timer;

  localparam int TB_TIMER_BITS    = 8;
  localparam int TB_PRESCALE_BITS = 4;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  prog_timer_if #(
    .TIMER_BITS   (TB_TIMER_BITS),
    .PRESCALE_BITS(TB_PRESCALE_BITS)
  ) bus ();

  prog_timer #(
    .TIMER_BITS   (TB_TIMER_BITS),
    .PRESCALE_BITS(TB_PRESCALE_BITS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the active edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    bus.enable        = 1'b0;
    bus.start         = 1'b0;
    bus.stop          = 1'b0;
    bus.mode_oneshot  = 1'b0;
    bus.dir_down      = 1'b0;
    bus.prescale      = '0;
    bus.final_value   = '0;
    bus.compare_value = '0;
    bus.irq_clr       = 1'b0;
`ifdef PROG_TIMER_CAPTURE_EN
    bus.capture_in    = 1'b0;
`endif

    // Reset values
    #1;
    chk("rst_count", bus.count, 0);
    chk("rst_running", bus.running, 0);
    chk("rst_tick", bus.tick, 0);
    chk("rst_irq", bus.irq, 0);
    chk("rst_cmp", bus.cmp_out, 0);
    repeat (3) cyc();
    reset = 1'b1;

    // Released, never started
    bus.enable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc();
      chk("idle_count", bus.count, 0);
      chk("idle_running", bus.running, 0);
      chk("idle_tick", bus.tick, 0);
      chk("idle_irq", bus.irq, 0);
    end

    // Up, periodic, prescale 0, final 3
    bus.final_value = 8'd3;
    pulse_start();
    for (int k = 0; k < 12; k++) begin
      chk("up_count", bus.count, k % 4);
      chk("up_tick", bus.tick, (k > 0) && (k % 4 == 0));
      chk("up_irq", bus.irq, k >= 4);
      chk("up_running", bus.running, 1);
      cyc();
    end
    bus.irq_clr = 1'b1;
    cyc();
    bus.irq_clr = 1'b0;
    chk("up_irqclr", bus.irq, 0);
    chk("up_count_after_clr", bus.count, 1);
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
    chk("stop_running", bus.running, 0);
    chk("stop_count", bus.count, 1);
    cyc();
    chk("stop_count_hold", bus.count, 1);

    // Down, one-shot, prescale 2, final 2
    bus.dir_down     = 1'b1;
    bus.mode_oneshot = 1'b1;
    bus.prescale     = 4'd2;
    bus.final_value  = 8'd2;
    pulse_start();
    for (int k = 0; k < 11; k++) begin
      chk("dn_count", bus.count, (k < 3) ? 2 : (k < 6) ? 1 : 0);
      chk("dn_running", bus.running, k < 9);
      chk("dn_tick", bus.tick, k == 9);
      chk("dn_irq", bus.irq, k >= 9);
      cyc();
    end
    bus.irq_clr = 1'b1;
    cyc();
    bus.irq_clr = 1'b0;
    chk("dn_irqclr", bus.irq, 0);

    // PWM: up periodic, final 9, compare 3
    bus.dir_down      = 1'b0;
    bus.mode_oneshot  = 1'b0;
    bus.prescale      = 4'd0;
    bus.final_value   = 8'd9;
    bus.compare_value = 8'd3;
    pulse_start();
    for (int k = 0; k < 15; k++) begin
      chk("pwm_count", bus.count, k % 10);
      chk("pwm_cmp", bus.cmp_out, (k % 10) < 3);
      chk("pwm_tick", bus.tick, k == 10);
      cyc();
    end
    bus.enable = 1'b0;
    for (int j = 0; j < 5; j++) begin
      cyc();
      chk("frz_count", bus.count, 5);
      chk("frz_cmp", bus.cmp_out, 0);
      chk("frz_running", bus.running, 1);
    end
    bus.enable = 1'b1;
    cyc();
    chk("unfrz_count", bus.count, 6);

    // start+stop together: stop wins
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    cyc();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    chk("ss_running", bus.running, 0);
    chk("ss_count", bus.count, 6);
    chk("ss_irq_set", bus.irq, 1);
    bus.irq_clr = 1'b1;
    cyc();
    bus.irq_clr = 1'b0;
    chk("ss_irqclr", bus.irq, 0);

    // irq_clr coincident with terminal: set wins
    bus.final_value = 8'd3;
    pulse_start();
    cyc();
    cyc();
    cyc();
    chk("coin_count3", bus.count, 3);
    bus.irq_clr = 1'b1;
    cyc();
    bus.irq_clr = 1'b0;
    chk("coin_irq", bus.irq, 1);
    chk("coin_tick", bus.tick, 1);
    chk("coin_count0", bus.count, 0);

    // final_value 0, up then down: every step terminal, count stays 0
    bus.final_value   = 8'd0;
    bus.compare_value = 8'd0;
    for (int d = 0; d < 2; d++) begin
      bus.dir_down = (d == 1);
      pulse_start();
      for (int k = 0; k < 5; k++) begin
        chk("fv0_count", bus.count, 0);
        chk("fv0_tick", bus.tick, k >= 1);
        chk("fv0_cmp", bus.cmp_out, 0);
        chk("fv0_running", bus.running, 1);
        cyc();
      end
    end

    // Reset mid-run: immediate return to reset values
    bus.dir_down    = 1'b0;
    bus.final_value = 8'd9;
    pulse_start();
    repeat (3) cyc();
    chk("mid_count_pre", bus.count, 3);
    reset = 1'b0;
    #1;
    chk("mid_rst_count", bus.count, 0);
    chk("mid_rst_running", bus.running, 0);
    chk("mid_rst_tick", bus.tick, 0);
    chk("mid_rst_irq", bus.irq, 0);
    cyc();
    reset = 1'b1;
    cyc();
    chk("post_rst_count", bus.count, 0);
    chk("post_rst_running", bus.running, 0);
    chk("post_rst_tick", bus.tick, 0);

`ifdef PROG_TIMER_CAPTURE_EN
    // Capture while parked at count 5
    chk("cap_rst_valid", bus.cap_valid, 0);
    chk("cap_rst_value", bus.capture_value, 0);
    pulse_start();
    repeat (5) cyc();
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
    chk("cap_count5", bus.count, 5);
    bus.capture_in = 1'b1;
    repeat (3) cyc();
    chk("cap_value", bus.capture_value, 5);
    chk("cap_valid", bus.cap_valid, 1);
    bus.irq_clr = 1'b1;
    cyc();
    bus.irq_clr = 1'b0;
    chk("cap_valid_clr", bus.cap_valid, 0);
    chk("cap_value_hold", bus.capture_value, 5);
    bus.capture_in = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
